// File: rtl/bench_result_uart.sv
// Serialises four captured 32-bit benchmark cycle counts as a 52-byte ASCII
// report ("Cn=XXXXXXXX\r\n" x4) on an 8N1 UART line.
//
// state | meaning
// IDLE  | line idle high, waiting for start
// START | start bit (low) for the current byte
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); then next byte or back to IDLE
module bench_result_uart #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] t_cond0,
  input  logic [31:0] t_cond1,
  input  logic [31:0] t_cond2,
  input  logic [31:0] t_cond3,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0] LAST_BYTE = 6'd51;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [5:0]        byte_idx_q, byte_idx_d;
  logic [3:0][31:0]  cap_q, cap_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]  cond_sel;
  logic [3:0]  char_pos;
  logic [31:0] cond_val;
  logic [3:0]  nib_idx;
  logic [31:0] cond_shifted;
  logic [3:0]  nibble;
  logic [7:0]  hex_char;
  logic [7:0]  cur_byte;

  // Character generator: byte index -> (line, column) -> ASCII code
  always_comb begin
    cond_sel     = 2'(byte_idx_q / 6'd13);
    char_pos     = 4'(byte_idx_q % 6'd13);
    cond_val     = cap_q[cond_sel];
    // columns 3..10 carry nibbles 7..0 of the value
    nib_idx      = 4'd10 - char_pos;
    cond_shifted = cond_val >> {nib_idx[2:0], 2'b00};
    nibble       = cond_shifted[3:0];
    hex_char     = (nibble < 4'd10) ? ({4'h0, nibble} + 8'h30) : ({4'h0, nibble} + 8'h37);
    case (char_pos)
      4'd0:    cur_byte = 8'h43;
      4'd1:    cur_byte = 8'h30 + {6'b0, cond_sel};
      4'd2:    cur_byte = 8'h3D;
      4'd11:   cur_byte = 8'h0D;
      4'd12:   cur_byte = 8'h0A;
      default: cur_byte = hex_char;
    endcase
  end

  // Next-state logic; bit timer is a down-counter reloaded at every bit boundary
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    cap_d      = cap_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          state_d    = START;
          cnt_d      = CNT_RELOAD;
          bit_idx_d  = 3'd0;
          byte_idx_d = 6'd0;
          cap_d      = {t_cond3, t_cond2, t_cond1, t_cond0};
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d   = DATA;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (byte_idx_q < LAST_BYTE) begin
            state_d    = START;
            cnt_d      = CNT_RELOAD;
            byte_idx_d = byte_idx_q + 6'd1;
            tx_d       = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any report in progress
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      cap_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      cap_q      <= cap_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/bench_result_uart.md
BENCH_RESULT_UART -- requirements
Module: bench_result_uart

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1085, meaning sysclk cycles per UART bit (125 MHz / 115200 baud); legal values are 2 and above.
REQ-002 SHALL have port sysclk, input, 1 bit: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to capture results and transmit one report.
REQ-005 SHALL have ports t_cond0, t_cond1, t_cond2, t_cond3, input, 32 bits each: benchmark cycle counts from the bench engine.
REQ-006 SHALL have port uart_tx, output, 1 bit: 8N1 serial line, idle high.
REQ-007 SHALL have port busy, output, 1 bit: high while a report is in progress.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse at report completion.

Function
REQ-009 SHALL accept start only when busy=0; start sampled high while busy=1 SHALL be ignored and not queued.
REQ-010 SHALL latch all four t_cond inputs on the accepting edge; later input changes SHALL NOT affect the report in progress.
REQ-011 SHALL emit exactly 52 bytes per report: for i=0..3 in order, 'C', ASCII digit i, '=', 8 uppercase hex digits of t_cond_i MSB nibble first, 0x0D, 0x0A.
REQ-012 SHALL map each nibble 0-9 to 0x30-0x39 and A-F to 0x41-0x46.
REQ-013 SHALL frame each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit exactly CLKS_PER_BIT cycles.
REQ-014 SHALL send bytes back-to-back with no idle gap between a stop bit and the next start bit.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on accepted start; START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START if byte index < 51, else STOP->IDLE.
REQ-016 SHALL drive uart_tx low and busy high from the edge that accepts start, so both are visible in the next cycle.
REQ-017 SHALL hold busy high for exactly 520*CLKS_PER_BIT cycles.
REQ-018 SHALL assert done for exactly one cycle, the cycle immediately after the final stop bit; busy SHALL be 0 in that cycle.
REQ-019 SHALL accept a start that arrives in the done cycle.
REQ-020 SHALL keep uart_tx high whenever in IDLE.
REQ-021 SHALL use a 6-bit byte index 0..51 that never wraps past 51.
REQ-022 SHALL use a bit-time counter of ceil(log2(CLKS_PER_BIT)) bits, reloaded at each bit boundary.

Reset
REQ-023 SHALL, while rst_n=0, force uart_tx=1, busy=0, done=0, state=IDLE, and clear all counters and captured data, independent of sysclk.
REQ-024 SHALL abort any report in progress on rst_n assertion, with no done pulse and no resumption after release.
REQ-025 SHALL accept a new start on the first rising edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4 unless noted)
REQ-026 SHALL pass a reset check: assert rst_n=0 mid-cycle -> uart_tx=1, busy=0, done=0 immediately, before any clock edge.
REQ-027 SHALL pass a message check: t_cond0=0x00001A2F, t_cond1=0xDEADBEEF, t_cond2=0x00000000, t_cond3=0xFFFFFFFF, 1-cycle start -> decoded stream "C0=00001A2F\r\nC1=DEADBEEF\r\nC2=00000000\r\nC3=FFFFFFFF\r\n", busy high 2080 cycles, then one done pulse.
REQ-028 SHALL pass a bit-timing check: first byte 'C' (0x43) -> uart_tx low 4 cycles, then data 1,1,0,0,0,0,1,0 at 4 cycles each, then high 4 cycles; next start bit follows immediately.
REQ-029 SHALL pass a busy-start check: start held high for 3000 cycles -> exactly one report during the first 2080 cycles, a second report accepted in the done cycle, and no extra bytes.
REQ-030 SHALL pass a capture check: start with t_cond0=0x12345678, then t_cond0 changed to 0x0 one cycle later -> report contains "C0=12345678".
REQ-031 SHALL pass a mid-report reset check: rst_n pulsed low during byte 20 -> uart_tx=1 at once, no done; after release and a new start, the full 52-byte report restarts from 'C'.
